sinc_dsm_modulator: RTL
=======================

Name: sinc_dsm_modulator

Overview:
- Transmit-side counterpart of the team's sinc3 decimation filter: takes PCM samples over a valid/ready handshake and emits a 4-bit unsigned code stream (0..15), one code per enable_in cycle.
- Each sample is held (zero-order hold) for oversample_in+1 enable cycles. The frame definition matches the decimator's, so modulator and decimator loop back cleanly.
- Noise shaping uses a second-order error-feedback modulator with NTF (1-z^-1)^2. It drives the 4-bit DAC/loopback path.

Parameters:
- FRAC_BITS, 12, fractional bits of input sample; input is unsigned fixed point, 4 integer bits plus FRAC_BITS fraction.
- IN_WIDTH, 4+FRAC_BITS, width of sample_in (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enable_in  in  1  modulator clock enable; one output code per enable cycle
- oversample_in  in  10  frame length minus 1, in enable cycles
- sample_in  in  IN_WIDTH  PCM sample, unsigned 4.FRAC_BITS
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  pending register empty
- data_out  out  4  modulator code
- data_valid_out  out  1  pulse: data_out updated
- frame_strobe_out  out  1  pulse: frame boundary, new sample taken
- underrun_out  out  1  pulse: boundary with no pending sample
- clip_out  out  1  pulse: accepted sample was clamped

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All outputs 0 except sample_ready=1. Error registers e1, e2 = 0, FSM = IDLE, counter = 0.
- Handshake:
  - sample_ready = !pending_valid (combinational).
  - A sample is accepted on valid&&ready. At accept, the value is clamped to [1<<FRAC_BITS, 14<<FRAC_BITS]; clip_out pulses the next cycle if the clamp changed the value.
  - A push and a consume cannot happen in the same cycle (ready=0 while pending is full).
- FSM state IDLE: no output activity.
  - On enable_in && pending_valid: active <= pending, pending_valid <= 0, ratio <= oversample_in, count <= 0, frame_strobe_out pulse, go to RUN.
  - No code is emitted on this cycle.
- FSM state RUN: each enable_in cycle:
  - u = x_active - 2*e1 + e2, computed in signed width IN_WIDTH+2.
  - y = floor(u), i.e. integer bits.
  - e = y - u, in range (-1,0], stored in signed FRAC_BITS+2 bits.
  - e2 <= e1, e1 <= e.
  - data_out <= y, data_valid_out <= 1 next cycle (1-cycle latency).
  - Input bounds [1,14] give u in (0,16), so y is always 0..15 and no saturation logic is required.
- Frame counter: increments per enable cycle in RUN. At the enable cycle where count == ratio:
  - count <= 0, ratio <= oversample_in (latched only here), frame_strobe_out pulses.
  - If pending_valid: active <= pending and pending_valid <= 0.
  - Otherwise: active is held and underrun_out pulses.
  - The new active value is first used on the following enable cycle.
- oversample_in = 0: every RUN enable cycle is a boundary.
- enable_in = 0: all state frozen; data_valid_out, frame_strobe_out and underrun_out are 0. Handshake still accepts into pending.
- Reset mid-run: returns to IDLE, drops pending and active samples, clears errors. data_out = 0 the cycle after rst.
- Pulse outputs are all single-cycle and registered.

Optional Feature:
- Macro SINC_DSM_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1 on reset, advances each RUN enable cycle.
  - When LFSR bit0 = 1, subtract 1 LSB (2^-FRAC_BITS) from u before quantization.
  - u stays >= 0, so the range is unchanged.
- Undefined: no LFSR, u as above; output exactly deterministic per the test plan.

Test Plan (dither off, FRAC_BITS = 12):
- Push 20480 (5.0), ratio 3, continuous enable -> data_out = 5 every cycle; frame_strobe_out every 4th enable cycle; no underrun while the source keeps ahead.
- Push 22528 (5.5) -> codes 5,6,6,5 repeating from first RUN cycle (e1,e2 = 0 at start); 4-cycle mean 5.5.
- Push 61440 (15.0) -> clip_out pulse one cycle after accept; data_out = 14 constant.
- Push a single sample (8.0), ratio 3, then no more -> underrun_out pulse at each 4th enable cycle; data_out stays 8; sample_ready = 1 throughout after the first load.
- Hold sample_valid high with two samples, toggle enable_in 1/0 -> second sample waits in pending (ready = 0); output and counter advance only on enable cycles; ratio change mid-frame takes effect only at the next boundary.
- Assert rst for 1 cycle mid-frame -> next cycle all outputs 0, sample_ready = 1, IDLE; re-push 5.5 reproduces the 5,6,6,5 sequence.

Source files
------------

// File: rtl/sinc_dsm_modulator.sv
// sinc_dsm_modulator: transmit-side partner of the sinc3 decimator.
// PCM samples (unsigned 4.FRAC_BITS) arrive over valid/ready. Each sample is
// held for oversample_in+1 enable cycles, and a second-order error-feedback
// modulator with NTF (1-z^-1)^2 turns it into a stream of 4-bit codes.
// Optional feature macro: SINC_DSM_DITHER_EN (LFSR dither ahead of the quantizer).
module sinc_dsm_modulator #(
  parameter int FRAC_BITS = 12,
  parameter int IN_WIDTH  = 4 + FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_in,
  input  logic [9:0]          oversample_in,
  input  logic [IN_WIDTH-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [3:0]          data_out,
  output logic                data_valid_out,
  output logic                frame_strobe_out,
  output logic                underrun_out,
  output logic                clip_out
);

  localparam int U_W = IN_WIDTH + 2;
  localparam int E_W = FRAC_BITS + 2;
  localparam logic [IN_WIDTH-1:0] CLAMP_LO = IN_WIDTH'(1) << FRAC_BITS;
  localparam logic [IN_WIDTH-1:0] CLAMP_HI = IN_WIDTH'(14) << FRAC_BITS;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [IN_WIDTH-1:0] pending;
  logic                pending_valid;
  logic [IN_WIDTH-1:0] active;
  logic [9:0]          ratio;
  logic [9:0]          count;
  logic signed [E_W-1:0] e1, e2;

  logic [IN_WIDTH-1:0] clamped;
  logic                clamp_hit;
  logic                accept;
  logic                take;
  logic                boundary;
  logic                run_step;

  logic signed [U_W-1:0] x_ext, e1_ext, e2_ext, u;
  logic [3:0]            y;
  logic signed [E_W-1:0] e_next;
  logic                  unused_u_msb;

`ifdef SINC_DSM_DITHER_EN
  localparam logic signed [U_W-1:0] U_LSB = 1;
  logic [15:0] lfsr;
`endif

  assign sample_ready = !pending_valid;
  assign accept       = sample_valid && !pending_valid;

  // Clamp incoming samples into [1.0, 14.0] so the quantizer never leaves 0..15
  always_comb begin
    clamped   = sample_in;
    clamp_hit = 1'b0;
    if (sample_in < CLAMP_LO) begin
      clamped   = CLAMP_LO;
      clamp_hit = 1'b1;
    end else if (sample_in > CLAMP_HI) begin
      clamped   = CLAMP_HI;
      clamp_hit = 1'b1;
    end
  end

  // Error-feedback quantizer: u = x - 2*e1 + e2, y = floor(u), e = y - u
  always_comb begin
    x_ext  = $signed({2'b00, active});
    e1_ext = {{(U_W - E_W){e1[E_W-1]}}, e1};
    e2_ext = {{(U_W - E_W){e2[E_W-1]}}, e2};
    u      = x_ext - (e1_ext <<< 1) + e2_ext;
`ifdef SINC_DSM_DITHER_EN
    if (lfsr[0]) begin
      u = u - U_LSB;
    end
`endif
    y      = u[FRAC_BITS+3:FRAC_BITS];
    e_next = -$signed({2'b00, u[FRAC_BITS-1:0]});
  end

  // u is always in (0,16), so the bits above the 4-bit code carry no information
  assign unused_u_msb = &{1'b0, u[U_W-1:FRAC_BITS+4]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control: loading, emitting and frame boundaries
  always_comb begin
    state_next = state;
    take       = 1'b0;
    boundary   = 1'b0;
    run_step   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in && pending_valid) begin
          take       = 1'b1;
          boundary   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (enable_in) begin
          run_step = 1'b1;
          if (count == ratio) begin
            boundary = 1'b1;
            take     = pending_valid;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pending/active sample registers, frame counter, error memory, pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pending          <= '0;
      pending_valid    <= 1'b0;
      active           <= '0;
      ratio            <= '0;
      count            <= '0;
      e1               <= '0;
      e2               <= '0;
      data_out         <= '0;
      data_valid_out   <= 1'b0;
      frame_strobe_out <= 1'b0;
      underrun_out     <= 1'b0;
      clip_out         <= 1'b0;
    end else begin
      data_valid_out   <= 1'b0;
      frame_strobe_out <= 1'b0;
      underrun_out     <= 1'b0;
      clip_out         <= 1'b0;

      if (accept) begin
        pending       <= clamped;
        pending_valid <= 1'b1;
        clip_out      <= clamp_hit;
      end

      if (take) begin
        active        <= pending;
        pending_valid <= 1'b0;
      end

      if (boundary) begin
        count            <= '0;
        ratio            <= oversample_in;
        frame_strobe_out <= 1'b1;
        underrun_out     <= !pending_valid;
      end else if (run_step) begin
        count <= count + 10'd1;
      end

      if (run_step) begin
        data_out       <= y;
        data_valid_out <= 1'b1;
        e2             <= e1;
        e1             <= e_next;
      end
    end
  end

`ifdef SINC_DSM_DITHER_EN
  // Dither source: x^16+x^14+x^13+x^11+1 Fibonacci LFSR, stepped once per emitted code
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (run_step) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`endif

endmodule
